mem_core_timed: RTL and testbench

//  Parametrised core-memory timing emulator: one start edge runs one timed cycle
//  (sense strobe, data latch, write-back, done). Sits between the CPU memory-control

---
 rtl/mem_core_timed_if.sv | 36 +++
 rtl/mem_core_timed.sv | 130 +++++++++++++
 tb/tb_mem_core_timed.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_core_timed_if.sv
// Bus between the CPU memory-control logic and the timed core-memory emulator.
// MEM_PARITY_EN adds the par_inj parity-injection input.
interface mem_core_timed_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 12
);
   logic              mem_start;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic              wr_inh;
   logic [DATA_W-1:0] data_out;
   logic              strobe_n;
   logic              mem_done_n;
   logic              busy;
   logic              overrun;
   logic              par_err_n;
`ifdef MEM_PARITY_EN
   logic              par_inj;
`endif

   modport master (
      output mem_start, addr, data_in, wr_inh,
`ifdef MEM_PARITY_EN
      output par_inj,
`endif
      input  data_out, strobe_n, mem_done_n, busy, overrun, par_err_n
   );

   modport slave (
      input  mem_start, addr, data_in, wr_inh,
`ifdef MEM_PARITY_EN
      input  par_inj,
`endif
      output data_out, strobe_n, mem_done_n, busy, overrun, par_err_n
   );
endinterface

// File: rtl/mem_core_timed.sv
// Core-memory timing emulator: a start edge runs one timed read/write-back cycle
// against an inferred block RAM. Optional parity storage/checking via MEM_PARITY_EN.
module mem_core_timed #(
   parameter int ADDR_W   = 15,
   parameter int DATA_W   = 12,
   parameter int STRB_ON  = 50,
   parameter int STRB_OFF = 60,
   parameter int READ_T   = 30,
   parameter int WRITE_T  = 80,
   parameter int DONE_T   = 149,
   parameter int CYCLE_T  = 160
) (
   input logic              clk,
   input logic              rst_n,
   mem_core_timed_if.slave  bus
);
   localparam int TW    = $clog2(CYCLE_T + 1);
   localparam int DEPTH = 1 << ADDR_W;
`ifdef MEM_PARITY_EN
   localparam int RW    = DATA_W + 1;
`else
   localparam int RW    = DATA_W;
`endif

   localparam logic [TW-1:0] T_ONE   = TW'(1);
   localparam logic [TW-1:0] T_SON   = TW'(STRB_ON);
   localparam logic [TW-1:0] T_SOFF  = TW'(STRB_OFF);
   localparam logic [TW-1:0] T_READ  = TW'(READ_T);
   localparam logic [TW-1:0] T_WRITE = TW'(WRITE_T);
   localparam logic [TW-1:0] T_DONE  = TW'(DONE_T);
   localparam logic [TW-1:0] T_CYCLE = TW'(CYCLE_T);

   if (!(2 <= READ_T && READ_T < WRITE_T && WRITE_T < DONE_T && DONE_T < CYCLE_T &&
         STRB_ON < STRB_OFF && STRB_OFF <= DONE_T)) begin : g_bad_params
      $error("mem_core_timed: illegal timing parameters");
   end

   typedef enum logic [1:0] {PH_IDLE, PH_ACTIVE, PH_DONE} phase_e;

   logic [TW-1:0]     timer_q, timer_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              prev_start_q, prev_start_d;
   logic              overrun_q, overrun_d;
   logic              par_err_n_q, par_err_n_d;
   logic [RW-1:0]     ram [DEPTH];
   logic [RW-1:0]     ram_q;
   logic [RW-1:0]     wr_word;
   logic              wr_en;
   logic              start_edge;
   logic              busy_w;
   logic              start;
   phase_e            phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q      <= '0;
         addr_q       <= '0;
         data_out_q   <= '0;
         prev_start_q <= 1'b0;
         overrun_q    <= 1'b0;
         par_err_n_q  <= 1'b1;
      end else begin
         timer_q      <= timer_d;
         addr_q       <= addr_d;
         data_out_q   <= data_out_d;
         prev_start_q <= prev_start_d;
         overrun_q    <= overrun_d;
         par_err_n_q  <= par_err_n_d;
      end
   end

   // The timer is the cycle state; the phase is a decoded view of it.
   always_comb begin
      phase        = PH_IDLE;
      start_edge   = bus.mem_start & ~prev_start_q;
      busy_w       = (timer_q != '0) && (timer_q < T_CYCLE);
      start        = start_edge & ~busy_w;
      timer_d      = timer_q;
      addr_d       = addr_q;
      data_out_d   = data_out_q;
      prev_start_d = bus.mem_start;
      overrun_d    = start_edge & busy_w;
      par_err_n_d  = par_err_n_q;
      wr_en        = (timer_q == T_WRITE) && !bus.wr_inh;
`ifdef MEM_PARITY_EN
      wr_word      = {(~^bus.data_in) ^ bus.par_inj, bus.data_in};
`else
      wr_word      = bus.data_in;
`endif

      if (timer_q >= T_DONE)
         phase = PH_DONE;
      else if (timer_q != '0)
         phase = PH_ACTIVE;

      if (start) begin
         timer_d = T_ONE;
         addr_d  = bus.addr;
      end else if (busy_w) begin
         timer_d = timer_q + T_ONE;
      end

      if (timer_q == T_READ) begin
         data_out_d = ram_q[DATA_W-1:0];
`ifdef MEM_PARITY_EN
         par_err_n_d = ^ram_q;
`endif
      end
   end

   // Block RAM: registered read of the latched address, single write pulse per cycle.
   always_ff @(posedge clk) begin
      if (wr_en)
         ram[addr_q] <= wr_word;
      ram_q <= ram[addr_q];
   end

   assign bus.data_out   = data_out_q;
   assign bus.strobe_n   = ~((timer_q >= T_SON) && (timer_q < T_SOFF));
   assign bus.mem_done_n = (phase != PH_DONE);
   assign bus.busy       = busy_w;
   assign bus.overrun    = overrun_q;
`ifdef MEM_PARITY_EN
   assign bus.par_err_n  = par_err_n_q;
`else
   assign bus.par_err_n  = 1'b1;
`endif

endmodule

// File: tb/tb_mem_core_timed.sv
// Directed self-checking bench for mem_core_timed; parity checks run only when
// MEM_PARITY_EN is defined.
module tb_mem_core_timed;
   localparam int CYCLE_T = 160;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   int          strbFirst, strbLast, strbCount, doneFall, ovrCount, ovrT;
   logic        busy1, busyEnd, p31;
   logic [11:0] d30, d31;

   mem_core_timed_if #(.ADDR_W(15), .DATA_W(12)) bus ();

   mem_core_timed dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0o expected %0o", tag, obs, exp);
      end
   endtask

   // One full cycle; samples on negedge so the observed timer value equals t.
   task automatic applyStimulus(input logic [14:0] a, input logic [11:0] d, input logic inh,
                                input logic inj, input int ovrAt, input int addrAt,
                                input logic [14:0] addrNew, input int rstAt);
      strbFirst = -1; strbLast = -1; strbCount = 0; doneFall = -1;
      ovrCount = 0; ovrT = -1;
      bus.addr = a; bus.data_in = d; bus.wr_inh = inh;
`ifdef MEM_PARITY_EN
      bus.par_inj = inj;
`else
      if (inj) $display("[TB] par_inj ignored in this build");
`endif
      bus.mem_start = 1'b1;
      for (int t = 1; t <= CYCLE_T; t++) begin
         @(posedge clk);
         @(negedge clk);
         if (t == 1) begin
            bus.mem_start = 1'b0;
            busy1 = bus.busy;
         end
         if (!bus.strobe_n) begin
            strbCount++;
            if (strbFirst < 0) strbFirst = t;
            strbLast = t;
         end
         if (doneFall < 0 && !bus.mem_done_n) doneFall = t;
         if (bus.overrun) begin
            ovrCount++;
            ovrT = t;
         end
         if (t == 30) d30 = bus.data_out;
         if (t == 31) begin
            d31 = bus.data_out;
            p31 = bus.par_err_n;
         end
         if (t == ovrAt) bus.mem_start = 1'b1;
         if (t == ovrAt + 1) bus.mem_start = 1'b0;
         if (t == addrAt) bus.addr = addrNew;
         if (t == rstAt) begin
            rst_n = 1'b0;
            #1;
            checkOutput("rst_mid_data_out", 32'(bus.data_out), 32'd0);
            checkOutput("rst_mid_strobe_n", 32'(bus.strobe_n), 32'd1);
            checkOutput("rst_mid_done_n", 32'(bus.mem_done_n), 32'd1);
            checkOutput("rst_mid_busy", 32'(bus.busy), 32'd0);
            checkOutput("rst_mid_overrun", 32'(bus.overrun), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
      end
      busyEnd = bus.busy;
      bus.mem_start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic readWord(input logic [14:0] a);
      applyStimulus(a, 12'o0000, 1'b1, 1'b0, -1, -1, 15'o0, -1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.mem_start = 1'b0;
      bus.addr = '0;
      bus.data_in = '0;
      bus.wr_inh = 1'b0;
`ifdef MEM_PARITY_EN
      bus.par_inj = 1'b0;
`endif
      repeat (3) @(negedge clk);
      checkOutput("reset_data_out", 32'(bus.data_out), 32'd0);
      checkOutput("reset_strobe_n", 32'(bus.strobe_n), 32'd1);
      checkOutput("reset_done_n", 32'(bus.mem_done_n), 32'd1);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_overrun", 32'(bus.overrun), 32'd0);
      checkOutput("reset_par_err_n", 32'(bus.par_err_n), 32'd1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      applyStimulus(15'o00123, 12'o7421, 1'b0, 1'b0, -1, -1, 15'o0, -1);
      checkOutput("strobe_first", 32'(strbFirst), 32'd50);
      checkOutput("strobe_last", 32'(strbLast), 32'd59);
      checkOutput("strobe_count", 32'(strbCount), 32'd10);
      checkOutput("done_fall", 32'(doneFall), 32'd149);
      checkOutput("busy_t1", 32'(busy1), 32'd1);
      checkOutput("busy_end", 32'(busyEnd), 32'd0);
      checkOutput("done_held", 32'(bus.mem_done_n), 32'd0);
      checkOutput("no_overrun", 32'(ovrCount), 32'd0);

      applyStimulus(15'o00456, 12'o3333, 1'b0, 1'b0, -1, -1, 15'o0, -1);
      readWord(15'o00456);
      checkOutput("read_456", 32'(bus.data_out), 32'o3333);
      readWord(15'o00123);
      checkOutput("data_out_t30_old", 32'(d30), 32'o3333);
      checkOutput("data_out_t31_new", 32'(d31), 32'o7421);
      readWord(15'o00123);
      checkOutput("inhibit_keeps_word", 32'(bus.data_out), 32'o7421);

      applyStimulus(15'o00200, 12'o1234, 1'b0, 1'b0, -1, 10, 15'o00456, -1);
      readWord(15'o00200);
      checkOutput("latched_addr_written", 32'(bus.data_out), 32'o1234);
      readWord(15'o00456);
      checkOutput("new_addr_untouched", 32'(bus.data_out), 32'o3333);

      applyStimulus(15'o00300, 12'o5555, 1'b0, 1'b0, 70, -1, 15'o0, -1);
      checkOutput("overrun_count", 32'(ovrCount), 32'd1);
      checkOutput("overrun_time", 32'(ovrT), 32'd71);
      checkOutput("overrun_done_fall", 32'(doneFall), 32'd149);
      readWord(15'o00300);
      checkOutput("overrun_write", 32'(bus.data_out), 32'o5555);

      applyStimulus(15'o00300, 12'o0000, 1'b1, 1'b0, 159, -1, 15'o0, -1);
      checkOutput("edge_at_end_overrun", 32'(ovrCount), 32'd1);
      checkOutput("edge_at_end_time", 32'(ovrT), 32'd160);
      checkOutput("edge_at_end_done", 32'(doneFall), 32'd149);
      readWord(15'o00123);
      checkOutput("after_boundary_read", 32'(bus.data_out), 32'o7421);

      applyStimulus(15'o00400, 12'o0707, 1'b0, 1'b0, -1, -1, 15'o0, -1);
      applyStimulus(15'o00400, 12'o7070, 1'b0, 1'b0, -1, -1, 15'o0, 60);
      readWord(15'o00400);
      checkOutput("reset_abort_no_write", 32'(bus.data_out), 32'o0707);

`ifdef MEM_PARITY_EN
      applyStimulus(15'o00500, 12'o0001, 1'b0, 1'b1, -1, -1, 15'o0, -1);
      readWord(15'o00500);
      checkOutput("par_inj_err_t31", 32'(p31), 32'd0);
      checkOutput("par_inj_err_held", 32'(bus.par_err_n), 32'd0);
      checkOutput("par_inj_data", 32'(bus.data_out), 32'o0001);
      applyStimulus(15'o00500, 12'o0001, 1'b0, 1'b0, -1, -1, 15'o0, -1);
      readWord(15'o00500);
      checkOutput("par_ok_t31", 32'(p31), 32'd1);
`else
      checkOutput("par_err_n_tied", 32'(bus.par_err_n), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
